uni_decode_exec: RTL and testbench

Single-cycle RV32I(M) decode/execute slice for the uniciclo datapath: instruction decoder, ALU, branch comparator, register-write-back mux and the PC register with next-PC selection. Register file, immediate generator and memory load/store formatters sit outside. Only the PC is clocked; everything else is combinational from the current instruction and operands.

---
 rtl/uni_decode_exec_pkg.sv | 67 ++++++
 rtl/uni_decode_exec_if.sv | 20 ++
 rtl/uni_alu.sv | 63 ++++++
 rtl/uni_decode_exec.sv | 165 ++++++++++++++++
 tb/tb_uni_decode_exec.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uni_decode_exec_pkg.sv
// Shared constants and types for the uniciclo decode/execute slice: opcodes, ALU operation
// codes, write-back and next-PC select encodings.
package uni_decode_exec_pkg;

  localparam logic [31:0] BEGINNING_TEXT = 32'h0040_0000;
  localparam logic [31:0] ZERO           = 32'h0000_0000;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Mext = 7'b0000001;

  typedef enum logic [4:0] {
    AluAnd    = 5'd0,  AluOr     = 5'd1,  AluXor  = 5'd2,  AluAdd  = 5'd3,
    AluSub    = 5'd4,  AluSlt    = 5'd5,  AluSltu = 5'd6,  AluSll  = 5'd7,
    AluSrl    = 5'd8,  AluSra    = 5'd9,  AluLui  = 5'd10, AluMul  = 5'd11,
    AluMulh   = 5'd12, AluMulhsu = 5'd13, AluMulhu = 5'd14, AluDiv = 5'd15,
    AluDivu   = 5'd16, AluRem    = 5'd17, AluRemu = 5'd18, AluNull = 5'd31
  } aluOp_e;

  typedef enum logic [1:0] {WbAlu = 2'b00, WbPc4 = 2'b01, WbMem = 2'b10, WbZero = 2'b11} mem2Reg_e;

  typedef enum logic [1:0] {
    PcPlus4 = 2'b00, PcBranch = 2'b01, PcJal = 2'b10, PcJalr = 2'b11
  } origPc_e;

  // funct3 mapping shared by OP and OP-IMM; the select flags pick SUB/SRA.
  function automatic aluOp_e baseAluOp(input logic [2:0] funct3, input logic subSel,
                                       input logic sraSel);
    aluOp_e op;
    unique case (funct3)
      3'b000:  op = subSel ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = sraSel ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  function automatic aluOp_e mulDivOp(input logic [2:0] funct3);
    aluOp_e op;
    unique case (funct3)
      3'b000:  op = AluMul;
      3'b001:  op = AluMulh;
      3'b010:  op = AluMulhsu;
      3'b011:  op = AluMulhu;
      3'b100:  op = AluDiv;
      3'b101:  op = AluDivu;
      3'b110:  op = AluRem;
      default: op = AluRemu;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/uni_decode_exec_if.sv
// Data and control bundle between the uniciclo datapath and its decode/execute slice.
interface uni_decode_exec_if;
  logic [31:0] iInitialPC, iInstr, iRead1, iRead2, iImm, iMemLoad;
  logic [31:0] oPC, oPC4, oALUResult, oRegWriteData;
  logic        oZero, oRegWrite, oMemRead, oMemWrite, oOrigAULA, oOrigBULA, oBranch;
  logic [1:0]  oMem2Reg, oOrigPC;
  logic [4:0]  oALUControl;

  modport master (
    output iInitialPC, iInstr, iRead1, iRead2, iImm, iMemLoad,
    input  oPC, oPC4, oALUResult, oRegWriteData, oZero, oRegWrite, oMemRead, oMemWrite,
           oOrigAULA, oOrigBULA, oBranch, oMem2Reg, oOrigPC, oALUControl
  );

  modport slave (
    input  iInitialPC, iInstr, iRead1, iRead2, iImm, iMemLoad,
    output oPC, oPC4, oALUResult, oRegWriteData, oZero, oRegWrite, oMemRead, oMemWrite,
           oOrigAULA, oOrigBULA, oBranch, oMem2Reg, oOrigPC, oALUControl
  );
endinterface

// File: rtl/uni_alu.sv
// RV32I ALU with optional M-extension multiply/divide (enabled by defining RV32M_EN).
module uni_alu
  import uni_decode_exec_pkg::*;
(
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  aluOp_e      iControl,
  output logic [31:0] oResult,
  output logic        oZero
);

`ifdef RV32M_EN
  logic signed [63:0] prodSS, prodSU;
  logic        [63:0] prodUU;
  logic               divOverflow;
  logic               unusedProd;

  assign prodSS      = $signed({{32{iA[31]}}, iA}) * $signed({{32{iB[31]}}, iB});
  assign prodSU      = $signed({{32{iA[31]}}, iA}) * $signed({32'b0, iB});
  assign prodUU      = {32'b0, iA} * {32'b0, iB};
  assign divOverflow = (iA == 32'h8000_0000) && (iB == 32'hFFFF_FFFF);
  assign unusedProd  = ^{prodSU[31:0], prodUU[31:0]};
`endif

  always_comb begin
    oResult = ZERO;
    case (iControl)
      AluAnd:  oResult = iA & iB;
      AluOr:   oResult = iA | iB;
      AluXor:  oResult = iA ^ iB;
      AluAdd:  oResult = iA + iB;
      AluSub:  oResult = iA - iB;
      AluSlt:  oResult = {31'b0, $signed(iA) < $signed(iB)};
      AluSltu: oResult = {31'b0, iA < iB};
      AluSll:  oResult = iA << iB[4:0];
      AluSrl:  oResult = iA >> iB[4:0];
      AluSra:  oResult = $signed(iA) >>> iB[4:0];
      AluLui:  oResult = iB;
`ifdef RV32M_EN
      AluMul:    oResult = prodSS[31:0];
      AluMulh:   oResult = prodSS[63:32];
      AluMulhsu: oResult = prodSU[63:32];
      AluMulhu:  oResult = prodUU[63:32];
      AluDiv: begin
        if (iB == ZERO)       oResult = 32'hFFFF_FFFF;
        else if (divOverflow) oResult = 32'h8000_0000;
        else                  oResult = $signed(iA) / $signed(iB);
      end
      AluDivu: oResult = (iB == ZERO) ? 32'hFFFF_FFFF : iA / iB;
      AluRem: begin
        if (iB == ZERO)       oResult = iA;
        else if (divOverflow) oResult = ZERO;
        else                  oResult = $signed(iA) % $signed(iB);
      end
      AluRemu: oResult = (iB == ZERO) ? iA : iA % iB;
`endif
      default: oResult = ZERO;
    endcase
  end

  assign oZero = (oResult == ZERO);

endmodule

// File: rtl/uni_decode_exec.sv
// Single-cycle RV32I(M) decode/execute slice: decoder, branch compare, write-back mux and PC.
// The M extension is decoded only when RV32M_EN is defined.
module uni_decode_exec
  import uni_decode_exec_pkg::*;
(
  input logic             iCLK,
  input logic             iRST,
  uni_decode_exec_if.slave bus
);

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        regWrite, memRead, memWrite, origA, origB, branch;
  mem2Reg_e    mem2Reg;
  origPc_e     origPc;
  aluOp_e      aluCtl;
  logic [31:0] pc, pc4, pcImm, jalrSum, pcD, aluA, aluB, aluResult, regWriteData;
  logic        aluZero, unusedInstr;
  // Holds PC ^ BEGINNING_TEXT so an all-zero power-up state reads as BEGINNING_TEXT.
  logic [31:0] pcQ;

  assign opcode      = bus.iInstr[6:0];
  assign funct3      = bus.iInstr[14:12];
  assign funct7      = bus.iInstr[31:25];
  assign unusedInstr = ^{bus.iInstr[24:15], bus.iInstr[11:7]};

  always_comb begin
    regWrite = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    origA    = 1'b0;
    origB    = 1'b0;
    mem2Reg  = WbAlu;
    origPc   = PcPlus4;
    aluCtl   = AluNull;
    case (opcode)
      OpcOp: begin
        if (funct7 == F7Mext) begin
`ifdef RV32M_EN
          regWrite = 1'b1;
          aluCtl   = mulDivOp(funct3);
`endif
        end else begin
          regWrite = 1'b1;
          aluCtl   = baseAluOp(funct3, funct7 == F7Alt, funct7 == F7Alt);
        end
      end
      OpcOpImm: begin
        origB    = 1'b1;
        regWrite = 1'b1;
        aluCtl   = baseAluOp(funct3, 1'b0, funct7[5]);
      end
      OpcLoad: begin
        origB    = 1'b1;
        aluCtl   = AluAdd;
        mem2Reg  = WbMem;
        regWrite = 1'b1;
        memRead  = 1'b1;
      end
      OpcStore: begin
        origB    = 1'b1;
        aluCtl   = AluAdd;
        memWrite = 1'b1;
      end
      OpcBranch: begin
        origPc = PcBranch;
        aluCtl = AluSub;
      end
      OpcJal: begin
        mem2Reg  = WbPc4;
        regWrite = 1'b1;
        origPc   = PcJal;
      end
      OpcJalr: begin
        mem2Reg  = WbPc4;
        regWrite = 1'b1;
        origPc   = PcJalr;
        origB    = 1'b1;
        aluCtl   = AluAdd;
      end
      OpcLui: begin
        origB    = 1'b1;
        aluCtl   = AluLui;
        regWrite = 1'b1;
      end
      OpcAuipc: begin
        origA    = 1'b1;
        origB    = 1'b1;
        aluCtl   = AluAdd;
        regWrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    branch = 1'b0;
    case (funct3)
      3'b000:  branch = (bus.iRead1 == bus.iRead2);
      3'b001:  branch = (bus.iRead1 != bus.iRead2);
      3'b100:  branch = ($signed(bus.iRead1) < $signed(bus.iRead2));
      3'b101:  branch = ($signed(bus.iRead1) >= $signed(bus.iRead2));
      3'b110:  branch = (bus.iRead1 < bus.iRead2);
      3'b111:  branch = (bus.iRead1 >= bus.iRead2);
      default: branch = 1'b0;
    endcase
  end

  assign aluA = origA ? pc : bus.iRead1;
  assign aluB = origB ? bus.iImm : bus.iRead2;

  uni_alu uAlu (
    .iA       (aluA),
    .iB       (aluB),
    .iControl (aluCtl),
    .oResult  (aluResult),
    .oZero    (aluZero)
  );

  always_comb begin
    regWriteData = ZERO;
    unique case (mem2Reg)
      WbAlu:  regWriteData = aluResult;
      WbPc4:  regWriteData = pc4;
      WbMem:  regWriteData = bus.iMemLoad;
      WbZero: regWriteData = ZERO;
    endcase
  end

  assign pc      = pcQ ^ BEGINNING_TEXT;
  assign pc4     = pc + 32'd4;
  assign pcImm   = pc + bus.iImm;
  assign jalrSum = bus.iRead1 + bus.iImm;

  always_comb begin
    pcD = pc4;
    unique case (origPc)
      PcPlus4:  pcD = pc4;
      PcBranch: pcD = branch ? pcImm : pc4;
      PcJal:    pcD = pcImm;
      PcJalr:   pcD = {jalrSum[31:1], 1'b0};
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) pcQ <= bus.iInitialPC ^ BEGINNING_TEXT;
    else      pcQ <= pcD ^ BEGINNING_TEXT;
  end

  assign bus.oPC           = pc;
  assign bus.oPC4          = pc4;
  assign bus.oALUResult    = aluResult;
  assign bus.oZero         = aluZero;
  assign bus.oRegWriteData = regWriteData;
  assign bus.oRegWrite     = regWrite;
  assign bus.oMemRead      = memRead;
  assign bus.oMemWrite     = memWrite;
  assign bus.oOrigAULA     = origA;
  assign bus.oOrigBULA     = origB;
  assign bus.oMem2Reg      = mem2Reg;
  assign bus.oOrigPC       = origPc;
  assign bus.oALUControl   = aluCtl;
  assign bus.oBranch       = branch;

endmodule

// File: tb/tb_uni_decode_exec.sv
// Self-checking bench for uni_decode_exec: directed scenarios plus randomized instructions
// checked against a behavioural model. Honours RV32M_EN like the design.
module tb_uni_decode_exec;

`ifdef RV32M_EN
  localparam bit MEn = 1'b1;
`else
  localparam bit MEn = 1'b0;
`endif

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  int   nVec = 0;
  int   nErr = 0;

  uni_decode_exec_if bus ();

  uni_decode_exec dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic        rw, mr, mw, oa, ob;
    logic [1:0]  m2r, opc;
    logic [4:0]  alu;
    logic [31:0] res;
    logic        zero, br;
    logic [31:0] wb, npc;
  } exp_t;

  function automatic logic [31:0] aluRef(input int op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = 64'd0;
    case (op)
      0:  p[31:0] = a & b;
      1:  p[31:0] = a | b;
      2:  p[31:0] = a ^ b;
      3:  p[31:0] = a + b;
      4:  p[31:0] = a - b;
      5:  p = (sa < sb) ? 64'd1 : 64'd0;
      6:  p = (ua < ub) ? 64'd1 : 64'd0;
      7:  p = ua << b[4:0];
      8:  p = ua >> b[4:0];
      9:  p = sa >>> b[4:0];
      10: p[31:0] = b;
      default: p = 64'd0;
    endcase
    if (MEn) begin
      case (op)
        11: p = sa * sb;
        12: begin p = sa * sb;  p = p >> 32; end
        13: begin p = sa * longint'(ub); p = p >> 32; end
        14: begin p = ua * ub;  p = p >> 32; end
        15: p = (b == 0) ? 64'hFFFF_FFFF : sa / sb;
        16: p = (b == 0) ? 64'hFFFF_FFFF : ua / ub;
        17: p = (b == 0) ? ua : sa % sb;
        18: p = (b == 0) ? ua : ua % ub;
        default: ;
      endcase
    end
    return p[31:0];
  endfunction

  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] imm, input logic [31:0] ld);
    exp_t        e;
    int          op;
    int          f3Op [8];
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b;
    f3Op = '{3, 7, 5, 6, 2, 8, 1, 0};
    f3 = instr[14:12];
    f7 = instr[31:25];
    e  = '0;
    op = 31;
    case (instr[6:0])
      7'h33: begin
        if (f7 == 7'h01) begin
          if (MEn) begin e.rw = 1; op = 11 + int'(f3); end
        end else begin
          e.rw = 1;
          op = f3Op[f3];
          if (f7 == 7'h20 && f3 == 3'd0) op = 4;
          if (f7 == 7'h20 && f3 == 3'd5) op = 9;
        end
      end
      7'h13: begin
        e.ob = 1; e.rw = 1;
        op = f3Op[f3];
        if (f3 == 3'd5 && f7[5]) op = 9;
      end
      7'h03: begin e.ob = 1; op = 3; e.m2r = 2; e.rw = 1; e.mr = 1; end
      7'h23: begin e.ob = 1; op = 3; e.mw = 1; end
      7'h63: begin e.opc = 1; op = 4; end
      7'h6F: begin e.m2r = 1; e.rw = 1; e.opc = 2; end
      7'h67: begin e.m2r = 1; e.rw = 1; e.opc = 3; e.ob = 1; op = 3; end
      7'h37: begin e.ob = 1; op = 10; e.rw = 1; end
      7'h17: begin e.oa = 1; e.ob = 1; op = 3; e.rw = 1; end
      default: ;
    endcase
    a      = e.oa ? pc : r1;
    b      = e.ob ? imm : r2;
    e.alu  = op[4:0];
    e.res  = aluRef(op, a, b);
    e.zero = (e.res == 0);
    case (f3)
      3'd0: e.br = (r1 == r2);
      3'd1: e.br = (r1 != r2);
      3'd4: e.br = ($signed(r1) < $signed(r2));
      3'd5: e.br = !($signed(r1) < $signed(r2));
      3'd6: e.br = (r1 < r2);
      3'd7: e.br = !(r1 < r2);
      default: e.br = 0;
    endcase
    case (e.m2r)
      2'd0: e.wb = e.res;
      2'd1: e.wb = pc + 4;
      2'd2: e.wb = ld;
      default: e.wb = 0;
    endcase
    case (e.opc)
      2'd0: e.npc = pc + 4;
      2'd1: e.npc = e.br ? pc + imm : pc + 4;
      2'd2: e.npc = pc + imm;
      default: e.npc = (r1 + imm) & 32'hFFFF_FFFE;
    endcase
    return e;
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [31:0] ld);
    bus.iInstr = instr; bus.iRead1 = r1; bus.iRead2 = r2; bus.iImm = imm; bus.iMemLoad = ld;
    #1;
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic resetTo(input logic [31:0] pc);
    iRST = 1'b1;
    bus.iInitialPC = pc;
    step();
    iRST = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] want [3];
    want = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008};
    drive(Nop, 0, 0, 0, 0);
    resetTo(32'h0040_0000);
    nVec++;
    if (bus.oPC4 !== 32'h0040_0004) begin
      nErr++; $display("FAIL reset_pc4: got %h expected %h", bus.oPC4, 32'h0040_0004);
    end
    for (int i = 0; i < 3; i++) begin
      nVec++;
      if (bus.oPC !== want[i]) begin
        nErr++; $display("FAIL reset_seq[%0d]: got %h expected %h", i, bus.oPC, want[i]);
      end
      step();
    end
  endtask

  task automatic test_alu();
    resetTo(32'h0000_1000);
    drive(32'h003100B3, 32'h7FFF_FFFF, 32'h1, 0, 0);
    nVec++;
    if (bus.oALUResult !== 32'h8000_0000 || bus.oRegWrite !== 1'b1) begin
      nErr++; $display("FAIL add_ovf: got %h rw=%b expected 80000000 rw=1",
                       bus.oALUResult, bus.oRegWrite);
    end
    drive(32'h403100B3, 32'd5, 32'd5, 0, 0);
    nVec++;
    if (bus.oALUResult !== 32'h0 || bus.oZero !== 1'b1) begin
      nErr++; $display("FAIL sub_zero: got %h z=%b expected 0 z=1", bus.oALUResult, bus.oZero);
    end
    step();
    nVec++;
    if (bus.oPC !== 32'h0000_1004) begin
      nErr++; $display("FAIL alu_pc: got %h expected %h", bus.oPC, 32'h0000_1004);
    end
  endtask

  task automatic test_branch();
    resetTo(32'h100);
    drive(32'h00208063, 32'd3, 32'd3, 32'hFFFF_FFF8, 0);
    step();
    nVec++;
    if (bus.oPC !== 32'hF8) begin
      nErr++; $display("FAIL beq_taken: got %h expected %h", bus.oPC, 32'hF8);
    end
    resetTo(32'h100);
    drive(32'h0020E063, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF8, 0);
    nVec++;
    if (bus.oBranch !== 1'b0) begin
      nErr++; $display("FAIL bltu_cond: got %b expected 0", bus.oBranch);
    end
    step();
    nVec++;
    if (bus.oPC !== 32'h104) begin
      nErr++; $display("FAIL bltu_pc: got %h expected %h", bus.oPC, 32'h104);
    end
    resetTo(32'h100);
    drive(32'h0020C063, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF8, 0);
    step();
    nVec++;
    if (bus.oPC !== 32'hF8) begin
      nErr++; $display("FAIL blt_taken: got %h expected %h", bus.oPC, 32'hF8);
    end
  endtask

  task automatic test_jalr();
    resetTo(32'h200);
    drive(32'h000080E7, 32'h1001, 32'h0, 32'h2, 0);
    nVec++;
    if (bus.oRegWriteData !== 32'h204) begin
      nErr++; $display("FAIL jalr_link: got %h expected %h", bus.oRegWriteData, 32'h204);
    end
    step();
    nVec++;
    if (bus.oPC !== 32'h1002) begin
      nErr++; $display("FAIL jalr_target: got %h expected %h", bus.oPC, 32'h1002);
    end
  endtask

  task automatic test_load_store();
    drive(32'h0000A083, 32'h10, 32'h0, 32'h4, 32'hCAFE_F00D);
    nVec++;
    if (bus.oMemRead !== 1'b1 || bus.oMem2Reg !== 2'b10) begin
      nErr++; $display("FAIL lw_ctrl: got mr=%b m2r=%b expected mr=1 m2r=10",
                       bus.oMemRead, bus.oMem2Reg);
    end
    nVec++;
    if (bus.oRegWriteData !== 32'hCAFE_F00D || bus.oALUResult !== 32'h14) begin
      nErr++; $display("FAIL lw_data: got wb=%h addr=%h expected wb=cafef00d addr=14",
                       bus.oRegWriteData, bus.oALUResult);
    end
    drive(32'h0020A023, 32'h10, 32'h55, 32'h8, 0);
    nVec++;
    if (bus.oMemWrite !== 1'b1 || bus.oRegWrite !== 1'b0 || bus.oALUResult !== 32'h18) begin
      nErr++; $display("FAIL sw_ctrl: got mw=%b rw=%b addr=%h expected mw=1 rw=0 addr=18",
                       bus.oMemWrite, bus.oRegWrite, bus.oALUResult);
    end
  endtask

  task automatic test_mext();
    logic [31:0] instr [4];
    logic [31:0] r1 [4];
    logic [31:0] r2 [4];
    logic [31:0] want [4];
    instr = '{32'h023140B3, 32'h023160B3, 32'h023140B3, 32'h023130B3};
    r1    = '{32'd7, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
    r2    = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    want  = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'hFFFF_FFFE};
    for (int i = 0; i < 4; i++) begin
      drive(instr[i], r1[i], r2[i], 0, 0);
      nVec++;
`ifdef RV32M_EN
      if (bus.oALUResult !== want[i] || bus.oRegWrite !== 1'b1) begin
        nErr++; $display("FAIL mext[%0d]: got %h rw=%b expected %h rw=1",
                         i, bus.oALUResult, bus.oRegWrite, want[i]);
      end
`else
      if (bus.oRegWrite !== 1'b0 || bus.oALUResult !== 32'h0 || bus.oOrigPC !== 2'b00) begin
        nErr++; $display("FAIL mext_nop[%0d]: got rw=%b res=%h opc=%b expected rw=0 res=0 opc=00",
                         i, bus.oRegWrite, bus.oALUResult, bus.oOrigPC);
      end
`endif
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(8);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [6:0]  opcs [11];
    logic [6:0]  f7s [3];
    logic [31:0] expPc, instr, r1, r2, imm, ld, initPc;
    logic [79:0] got, want;
    exp_t        e;
    bit          rst;
    opcs = '{7'h33, 7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
    f7s  = '{7'h00, 7'h20, 7'h01};
    resetTo(32'h0040_0000);
    expPc = 32'h0040_0000;
    for (int i = 0; i < 400; i++) begin
      instr      = $urandom;
      instr[6:0] = opcs[$urandom_range(10)];
      if (instr[6:0] == 7'h33) instr[31:25] = f7s[$urandom_range(2)];
      if (($urandom_range(15)) == 0) instr[6:0] = 7'h0F;
      r1 = pick(); r2 = pick(); imm = pick(); ld = $urandom;
      drive(instr, r1, r2, imm, ld);
      e = model(instr, expPc, r1, r2, imm, ld);
      got  = {bus.oRegWrite, bus.oMemRead, bus.oMemWrite, bus.oOrigAULA, bus.oOrigBULA,
              bus.oMem2Reg, bus.oOrigPC, bus.oALUControl, bus.oALUResult, bus.oZero,
              bus.oBranch, bus.oRegWriteData};
      want = {e.rw, e.mr, e.mw, e.oa, e.ob, e.m2r, e.opc, e.alu, e.res, e.zero, e.br, e.wb};
      nVec++;
      if (got !== want) begin
        nErr++; $display("FAIL rand_outputs[%0d] instr=%h a=%h b=%h imm=%h: got %h expected %h",
                         i, instr, r1, r2, imm, got, want);
      end
      nVec++;
      if (bus.oPC !== expPc || bus.oPC4 !== expPc + 32'd4) begin
        nErr++; $display("FAIL rand_pc[%0d]: got %h/%h expected %h/%h",
                         i, bus.oPC, bus.oPC4, expPc, expPc + 32'd4);
      end
      rst = ($urandom_range(24) == 0);
      initPc = $urandom;
      iRST = rst;
      bus.iInitialPC = initPc;
      step();
      iRST = 1'b0;
      expPc = rst ? initPc : e.npc;
    end
  endtask

  initial begin
    bus.iInitialPC = 32'h0040_0000;
    drive(Nop, 0, 0, 0, 0);
    test_reset();
    test_alu();
    test_branch();
    test_jalr();
    test_load_store();
    test_mext();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
